radix8_ntt_ctrl: RTL and testbench

Sequencer for the radix-8 NTT/INTT datapath: the butterfly, the mode switch and the modular multiplier. It runs all stages of one transform over an N-point polynomial memory. For each butterfly group it issues a memory read (base address and stride), the twiddle ROM address and the mode-switch `select`, then issues the matching write-back after the fixed datapath latency. It sits between the top-level start/done handshake and the coefficient RAM / twiddle ROM address ports.

---
 rtl/ntt_ctrl_pkg.sv | 24 ++
 rtl/ntt_addr_gen.sv | 44 ++++
 rtl/radix8_ntt_ctrl.sv | 142 ++++++++++++++
 tb/tb_radix8_ntt_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_ctrl_pkg.sv
// Shared FSM encoding and constants for the radix-8 NTT sequencer (radix8_ntt_ctrl, ntt_addr_gen).
// Optional feature macro used by the importers: NTT_CTRL_INTT_EN.
package ntt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned PIPE_LAT_DEF = 4;

  // Address bits consumed by one radix-8 digit: stride 8^k is a shift by 3k.
  localparam int unsigned LOG8_BITS = 3;

  // Width of stage / stride-log fields; never narrower than 2 bits.
  function automatic int unsigned stage_w(input int unsigned s);
    int unsigned w;
    w = $clog2(s);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational map from (group, stage, mode) to read base, stride log and twiddle index.
// NTT_CTRL_INTT_EN: when defined, mode=1 selects the small-to-large (INTT) stride order.
module ntt_addr_gen
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned S      = 3,
  parameter int unsigned ADDR_W = 9,
  localparam int unsigned SW    = stage_w(S),
  localparam int unsigned GW    = ADDR_W - 3
) (
  input  logic [GW-1:0]     g,
  input  logic [SW-1:0]     stage,
  input  logic              mode,
  output logic [ADDR_W-1:0] rd_base,
  output logic [SW-1:0]     rd_stride_log,
  output logic [GW-1:0]     tw_addr
);

  localparam logic [SW-1:0] S_LAST = SW'(S - 1);

  logic [7:0]    sh;
  logic [GW-1:0] mask;
  logic [GW-1:0] offset;
  logic [GW-1:0] block;

`ifdef NTT_CTRL_INTT_EN
  assign rd_stride_log = mode ? stage : S_LAST - stage;
`else
  logic unused_mode;
  assign unused_mode   = mode;
  assign rd_stride_log = S_LAST - stage;
`endif

  // Stride t = 2^sh: offset = g mod t, block = g / t, twiddle = offset * 8^(S-1) / t.
  always_comb begin
    sh      = 8'(rd_stride_log) * 8'(LOG8_BITS);
    mask    = (GW'(1) << sh) - GW'(1);
    offset  = g & mask;
    block   = g >> sh;
    rd_base = (ADDR_W'(block) << (sh + 8'(LOG8_BITS))) | ADDR_W'(offset);
    tw_addr = offset << (8'(LOG8_BITS * (S - 1)) - sh);
  end

endmodule

// File: rtl/radix8_ntt_ctrl.sv
// Radix-8 NTT/INTT stage sequencer: group FSM, registered read-address issue, write-back delay line.
// NTT_CTRL_INTT_EN: when defined, mode is latched on start and drives select / INTT stride order.
module radix8_ntt_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned N        = 512,
  parameter int unsigned S        = 3,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
  localparam int unsigned SW      = stage_w(S)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              select,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_base,
  output logic [SW-1:0]     rd_stride_log,
  output logic [ADDR_W-4:0] tw_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_base,
  output logic [SW-1:0]     stage
);

  localparam int unsigned   GW     = ADDR_W - 3;
  localparam logic [GW-1:0] G_LAST = GW'(N / 8 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(S - 1);

  state_t                          state, state_n;
  logic [GW-1:0]                   g, g_n;
  logic [SW-1:0]                   stage_n;
  logic                            sel_n;
  logic                            mode_in;
  logic                            pending;
  logic [ADDR_W-1:0]               ag_base;
  logic [SW-1:0]                   ag_sl;
  logic [GW-1:0]                   ag_tw;
  logic [PIPE_LAT-1:0]             dl_v;
  logic [PIPE_LAT-1:0][ADDR_W-1:0] dl_b;

`ifdef NTT_CTRL_INTT_EN
  assign mode_in = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_in     = 1'b0;
`endif

  // Address map runs on next-state values so the read outputs can be plain registers.
  ntt_addr_gen #(
    .S      (S),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .g             (g_n),
    .stage         (stage_n),
    .mode          (sel_n),
    .rd_base       (ag_base),
    .rd_stride_log (ag_sl),
    .tw_addr       (ag_tw)
  );

  always_comb begin
    state_n = state;
    g_n     = g;
    stage_n = stage;
    sel_n   = select;
    // Writes still in flight after this cycle; the head entry lands now.
    pending = rd_en;
    for (int unsigned i = 0; i + 1 < PIPE_LAT; i++) begin
      pending = pending | dl_v[i];
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          g_n     = '0;
          stage_n = '0;
          sel_n   = mode_in;
        end
      end
      READ: begin
        g_n = g + GW'(1);
        if (g == G_LAST) state_n = DRAIN;
      end
      DRAIN: begin
        if (!pending) begin
          if (stage == S_LAST) begin
            state_n = DONE;
          end else begin
            state_n = READ;
            stage_n = stage + SW'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      g             <= '0;
      stage         <= '0;
      select        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_en         <= 1'b0;
      rd_base       <= '0;
      rd_stride_log <= '0;
      tw_addr       <= '0;
      dl_v          <= '0;
      dl_b          <= '0;
    end else begin
      state  <= state_n;
      g      <= g_n;
      stage  <= stage_n;
      select <= sel_n;
      busy   <= (state_n == READ) || (state_n == DRAIN);
      done   <= (state_n == DONE);
      rd_en  <= (state_n == READ);
      if (state_n == READ) begin
        rd_base       <= ag_base;
        rd_stride_log <= ag_sl;
        tw_addr       <= ag_tw;
      end
      dl_v[0] <= rd_en;
      dl_b[0] <= rd_base;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  assign wr_en   = dl_v[PIPE_LAT-1];
  assign wr_base = dl_b[PIPE_LAT-1];

endmodule

// File: tb/tb_radix8_ntt_ctrl.sv
// Scoreboard bench for radix8_ntt_ctrl: default build (N=512, PIPE_LAT=4) plus a small N=64, PIPE_LAT=1 instance.
// Honours NTT_CTRL_INTT_EN when choosing the expected stride order and select value.
module tb_radix8_ntt_ctrl;

  localparam int N1 = 512, S1 = 3, A1 = 9, P1 = 4;
  localparam int N2 = 64,  S2 = 2, A2 = 6, P2 = 1;

  typedef struct {
    int cyc;
    int base;
    int tw;
    int sl;
    int stg;
    int sel;
  } rd_t;

  typedef struct {
    int cyc;
    int base;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, mode1 = 1'b0, start2 = 1'b0, mode2 = 1'b0;

  logic          busy1, done1, sel1, rd_en1, wr_en1;
  logic [A1-1:0] rd_base1, wr_base1;
  logic [A1-4:0] tw1;
  logic [1:0]    sl1, stage1;

  logic          busy2, done2, sel2, rd_en2, wr_en2;
  logic [A2-1:0] rd_base2, wr_base2;
  logic [A2-4:0] tw2;
  logic [1:0]    sl2, stage2;

  radix8_ntt_ctrl #(.N(N1), .S(S1), .ADDR_W(A1), .PIPE_LAT(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
    .busy(busy1), .done(done1), .select(sel1), .rd_en(rd_en1),
    .rd_base(rd_base1), .rd_stride_log(sl1), .tw_addr(tw1),
    .wr_en(wr_en1), .wr_base(wr_base1), .stage(stage1)
  );

  radix8_ntt_ctrl #(.N(N2), .S(S2), .ADDR_W(A2), .PIPE_LAT(P2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
    .busy(busy2), .done(done2), .select(sel2), .rd_en(rd_en2),
    .rd_base(rd_base2), .rd_stride_log(sl2), .tw_addr(tw2),
    .wr_en(wr_en2), .wr_base(wr_base2), .stage(stage2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  rd_t rq1[$], rq2[$];
  wr_t wq1[$], wq2[$];
  int  dq1[$], dq2[$];
  int  b1_from = 0, b1_to = 0;
  int  wr_cnt1 = 0, wr_cnt2 = 0;
  int  last_stg2 = -1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int eff(input int m);
`ifdef NTT_CTRL_INTT_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction

  // Expected transform from the stage/stride rules, with arithmetic div/mod.
  task automatic push_run(input int which, input int t0, input int m,
                          input int nn, input int ss, input int pp);
    int per;
    per = nn / 8 + pp;
    for (int s = 0; s < ss; s++) begin
      int sl;
      int t;
      sl = (m != 0) ? s : ss - 1 - s;
      t  = 1;
      for (int k = 0; k < sl; k++) t = t * 8;
      for (int g = 0; g < nn / 8; g++) begin
        rd_t r;
        wr_t w;
        r.cyc  = t0 + 1 + s * per + g;
        r.base = (g / t) * 8 * t + (g % t);
        r.tw   = (g % t) * (nn / 8) / t;
        r.sl   = sl;
        r.stg  = s;
        r.sel  = m;
        w.cyc  = r.cyc + pp;
        w.base = r.base;
        if (which == 0) begin rq1.push_back(r); wq1.push_back(w); end
        else            begin rq2.push_back(r); wq2.push_back(w); end
      end
    end
    if (which == 0) dq1.push_back(t0 + 1 + ss * per);
    else            dq2.push_back(t0 + 1 + ss * per);
  endtask

  // Monitor for the default-parameter instance.
  always begin
    rd_t r;
    wr_t w;
    @(posedge clk);
    #1;
    chk("busy1", int'(busy1), int'(cyc >= b1_from && cyc < b1_to));
    if (rd_en1) begin
      if (rq1.size() == 0) chk("rd1_unexpected", 1, 0);
      else begin
        r = rq1.pop_front();
        chk("rd1_cyc", cyc, r.cyc);
        chk("rd1_base", int'(rd_base1), r.base);
        chk("rd1_tw", int'(tw1), r.tw);
        chk("rd1_stride_log", int'(sl1), r.sl);
        chk("rd1_stage", int'(stage1), r.stg);
        chk("rd1_select", int'(sel1), r.sel);
      end
    end
    if (wr_en1) begin
      wr_cnt1++;
      if (wq1.size() == 0) chk("wr1_unexpected", 1, 0);
      else begin
        w = wq1.pop_front();
        chk("wr1_cyc", cyc, w.cyc);
        chk("wr1_base", int'(wr_base1), w.base);
      end
    end
    if (done1) begin
      if (dq1.size() == 0) chk("done1_unexpected", 1, 0);
      else chk("done1_cyc", cyc, dq1.pop_front());
    end
  end

  // Monitor for the N=64, PIPE_LAT=1 instance.
  always begin
    rd_t r;
    wr_t w;
    @(posedge clk);
    #1;
    if (rd_en2) begin
      if (int'(stage2) != last_stg2) begin
        chk("raw_gap2", wr_cnt2, int'(stage2) * (N2 / 8));
        last_stg2 = int'(stage2);
      end
      if (rq2.size() == 0) chk("rd2_unexpected", 1, 0);
      else begin
        r = rq2.pop_front();
        chk("rd2_cyc", cyc, r.cyc);
        chk("rd2_base", int'(rd_base2), r.base);
        chk("rd2_tw", int'(tw2), r.tw);
        chk("rd2_stride_log", int'(sl2), r.sl);
      end
    end
    if (wr_en2) begin
      wr_cnt2++;
      if (wq2.size() == 0) chk("wr2_unexpected", 1, 0);
      else begin
        w = wq2.pop_front();
        chk("wr2_cyc", cyc, w.cyc);
        chk("wr2_base", int'(wr_base2), w.base);
      end
    end
    if (done2) begin
      if (dq2.size() == 0) chk("done2_unexpected", 1, 0);
      else chk("done2_cyc", cyc, dq2.pop_front());
    end
  end

  task automatic run1(input int m, input int poke50, input int rst100);
    int t0;
    int wbase;
    int k;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    t0      = cyc;
    start1  = 1'b1;
    mode1   = (m != 0);
    push_run(0, t0, eff(m), N1, S1, P1);
    b1_from = t0 + 1;
    b1_to   = t0 + 1 + S1 * (N1 / 8 + P1);
    wbase   = wr_cnt1;
    @(negedge clk);
    start1 = 1'b0;
    mode1  = 1'($urandom);
    if (poke50 != 0) begin
      while (cyc < t0 + 50) @(negedge clk);
      start1 = 1'b1;
      mode1  = (m == 0);
      @(negedge clk);
      start1 = 1'b0;
    end
    if (rst100 != 0) begin
      while (cyc < t0 + 100) @(negedge clk);
      rst_n = 1'b0;
      rq1.delete();
      wq1.delete();
      dq1.delete();
      b1_to = t0 + 101;
      @(negedge clk);
      rst_n = 1'b1;
      wbase = wr_cnt1;
      chk("midrst_busy", int'(busy1), 0);
      chk("midrst_rd_en", int'(rd_en1), 0);
      repeat (12) @(negedge clk);
      chk("midrst_no_wr", wr_cnt1 - wbase, 0);
      return;
    end
    k = 0;
    while (!done1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("done1_wait", cyc, t0 + 1 + S1 * (N1 / 8 + P1));
    start1 = 1'b1;
    mode1  = 1'($urandom);
    @(negedge clk);
    start1 = 1'b0;
    chk("wr1_count", wr_cnt1 - wbase, S1 * N1 / 8);
  endtask

  initial begin
    int t0;
    int k;
    rst_n  = 1'b0;
    start1 = 1'b1;
    mode1  = 1'b1;
    start2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_rd_en", int'(rd_en1), 0);
    chk("rst_wr_en", int'(wr_en1), 0);
    chk("rst_select", int'(sel1), 0);
    chk("rst_rd_base", int'(rd_base1), 0);
    chk("rst_wr_base", int'(wr_base1), 0);
    chk("rst_tw_addr", int'(tw1), 0);
    chk("rst_stage", int'(stage1), 0);
    chk("rst_stride_log", int'(sl1), 0);
    chk("rst_busy2", int'(busy2), 0);
    start1 = 1'b0;
    mode1  = 1'b0;
    start2 = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    run1(0, 0, 0);
    run1(1, 0, 0);
    run1(int'($urandom_range(0, 1)), 1, 0);
    run1(int'($urandom_range(0, 1)), 0, 1);
    run1(int'($urandom_range(0, 1)), 0, 0);
    run1(int'($urandom_range(0, 1)), 1, 0);

    repeat ($urandom_range(1, 4)) @(negedge clk);
    t0     = cyc;
    start2 = 1'b1;
    mode2  = 1'b0;
    push_run(1, t0, 0, N2, S2, P2);
    @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (!done2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done2_wait", cyc, t0 + 19);
    @(negedge clk);
    chk("wr2_count", wr_cnt2, S2 * N2 / 8);

    repeat (4) @(negedge clk);
    chk("rq1_left", rq1.size(), 0);
    chk("wq1_left", wq1.size(), 0);
    chk("dq1_left", dq1.size(), 0);
    chk("rq2_left", rq2.size(), 0);
    chk("wq2_left", wq2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
